// File: rtl/instr_stream_encoder.sv
// Encodes structured instruction requests (R/LW/SW/BEQ/J) into 32-bit MIPS words
// and streams them into instruction memory starting at BASE.
module instr_stream_encoder #(
    parameter int AW    = 8,
    parameter int DEPTH = 256,
    parameter int BASE  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_kind,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_shamt,
    input  logic [5:0]    in_funct,
    input  logic [15:0]   in_imm,
    input  logic [25:0]   in_target,
    input  logic          in_last,
    output logic          im_we,
    input  logic          im_ready,
    output logic [AW-1:0] im_addr,
    output logic [31:0]   im_wdata,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count,
    output logic          err_illegal,
    output logic          err_overflow,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] BASE_W  = (AW+1)'(BASE);

    state_t      state;
    logic        accept;
    logic        legal;
    logic [31:0] enc;
    logic [AW:0] addr_sum;

    // Valid/ready: a request (or memory write) transfers on any edge where both are high.
    assign in_ready  = (state == LOAD) && (!im_we || im_ready);
    assign accept    = in_valid && in_ready;
    assign addr_sum  = BASE_W + count;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign dbg_state = state;

    always_comb begin
        enc   = 32'h0;
        legal = 1'b1;
        case (in_kind)
            3'd0:    enc = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
            3'd1:    enc = {6'b100011, in_rs, in_rt, in_imm};
            3'd2:    enc = {6'b101011, in_rs, in_rt, in_imm};
            3'd3:    enc = {6'b000100, in_rs, in_rt, in_imm};
            3'd4:    enc = {6'b000010, in_target};
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            im_we        <= 1'b0;
            im_addr      <= '0;
            im_wdata     <= '0;
            count        <= '0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= LOAD;
                        count        <= '0;
                        err_illegal  <= 1'b0;
                        err_overflow <= 1'b0;
                    end
                end
                LOAD: begin
                    if (im_we && im_ready) im_we <= 1'b0;
                    if (accept) begin
                        if (!legal) begin
                            err_illegal <= 1'b1;
                            if (in_last) state <= DRAIN;
                        end else if (count == DEPTH_W) begin
                            // Full program: drop the word and stop loading.
                            err_overflow <= 1'b1;
                            state        <= DRAIN;
                        end else begin
                            im_we    <= 1'b1;
                            im_wdata <= enc;
                            im_addr  <= addr_sum[AW-1:0];
                            count    <= count + 1'b1;
                            if (in_last) state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (im_we && im_ready) im_we <= 1'b0;
                    if (!im_we) state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed-vector bench for instr_stream_encoder with a write scoreboard.
module tb_instr_stream_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_kind = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [5:0]  in_funct = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        in_last = 1'b0;
    logic        im_we;
    logic        im_ready = 1'b1;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;
    logic        busy, done;
    logic [8:0]  count;
    logic        err_illegal, err_overflow;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [39:0] exp_q[$];

    instr_stream_encoder #(.AW(8), .DEPTH(4), .BASE(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata),
        .busy(busy), .done(done), .count(count), .err_illegal(err_illegal),
        .err_overflow(err_overflow), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: sample just before each rising edge, when inputs and outputs are settled.
    always @(negedge clk) begin
        #4;
        if (im_we && im_ready) begin
            if (exp_q.size() == 0) begin
                chk("wr_extra", 32'(im_addr), 32'hFFFF_FFFF);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(im_addr), 32'(e[39:32]));
                chk("wr_data", im_wdata, e[31:0]);
            end
        end
    end

    // driver tasks (called at a falling edge, return at a falling edge)
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] funct,
                        input logic [15:0] imm, input logic [25:0] target, input logic last);
        int n;
        in_valid = 1'b1; in_kind = kind; in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = shamt; in_funct = funct; in_imm = imm; in_target = target; in_last = last;
        n = 0;
        #4;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #4;
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    initial begin
        // reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_im_we", 32'(im_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_err_ill", 32'(err_illegal), 0);
        chk("rst_err_ovf", 32'(err_overflow), 0);
        chk("rst_addr", 32'(im_addr), 0);
        chk("rst_wdata", im_wdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single R-type
        pulse_start();
        chk("t1_busy", 32'(busy), 1);
        expect_wr(8'd0, 32'h0022_1820);
        send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1);
        wait_done();
        chk("t1_count", 32'(count), 1);
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_idle", 32'(busy), 0);
        chk("t1_left", 32'(exp_q.size()), 0);

        // 2: LW, SW, BEQ back-to-back
        pulse_start();
        expect_wr(8'd0, 32'h8C08_0004);
        expect_wr(8'd1, 32'hAC08_0008);
        expect_wr(8'd2, 32'h1022_FFFF);
        send(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b0);
        send(3'd2, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0008, 26'h0, 1'b0);
        send(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0, 1'b1);
        wait_done();
        chk("t2_count", 32'(count), 3);
        chk("t2_left", 32'(exp_q.size()), 0);
        @(negedge clk);

        // 3: J held under memory back-pressure
        pulse_start();
        im_ready = 1'b0;
        expect_wr(8'd0, 32'h0800_0010);
        send(3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h000_0010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_we", 32'(im_we), 1);
            chk("t3_hold_data", im_wdata, 32'h0800_0010);
            chk("t3_hold_addr", 32'(im_addr), 0);
            chk("t3_in_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        im_ready = 1'b1;
        expect_wr(8'd1, 32'h0085_3080);
        send(3'd0, 5'd4, 5'd5, 5'd6, 5'd2, 6'h00, 16'h0, 26'h0, 1'b1);
        wait_done();
        chk("t3_count", 32'(count), 2);
        chk("t3_left", 32'(exp_q.size()), 0);
        @(negedge clk);

        // 4: illegal kind between two legal words
        pulse_start();
        expect_wr(8'd0, 32'h0022_1820);
        expect_wr(8'd1, 32'h8C08_0004);
        send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0);
        send(3'd6, 5'd1, 5'd1, 5'd1, 5'd1, 6'h01, 16'h1, 26'h1, 1'b0);
        send(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b1);
        wait_done();
        chk("t4_err_ill", 32'(err_illegal), 1);
        chk("t4_err_ovf", 32'(err_overflow), 0);
        chk("t4_count", 32'(count), 2);
        chk("t4_left", 32'(exp_q.size()), 0);
        @(negedge clk);

        // 5: overflow at DEPTH=4, with an illegal word on the full count first
        pulse_start();
        chk("t5_err_clr", 32'(err_illegal), 0);
        for (int i = 0; i < 4; i++) begin
            expect_wr(8'(i), {6'b000010, 26'(i + 1)});
            send(3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'(i + 1), 1'b0);
        end
        send(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b0);
        chk("t5_full_ill", 32'(err_illegal), 1);
        chk("t5_full_ovf", 32'(err_overflow), 0);
        chk("t5_full_busy", 32'(busy), 1);
        send(3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'd5, 1'b0);
        wait_done();
        chk("t5_err_ovf", 32'(err_overflow), 1);
        chk("t5_count", 32'(count), 4);
        @(negedge clk);
        chk("t5_in_ready", 32'(in_ready), 0);
        chk("t5_left", 32'(exp_q.size()), 0);

        // 6: reset during a pending write, then reload from BASE
        pulse_start();
        chk("t6_err_clr", 32'(err_overflow), 0);
        chk("t6_cnt_clr", 32'(count), 0);
        im_ready = 1'b0;
        send(3'd0, 5'd7, 5'd7, 5'd7, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0);
        chk("t6_pending", 32'(im_we), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_we", 32'(im_we), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_addr", 32'(im_addr), 0);
        chk("t6_rst_wdata", im_wdata, 0);
        chk("t6_rst_count", 32'(count), 0);
        chk("t6_rst_ready", 32'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        im_ready = 1'b1;
        @(negedge clk);
        pulse_start();
        expect_wr(8'd0, 32'h8C08_0004);
        send(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b1);
        wait_done();
        chk("t6_count", 32'(count), 1);
        chk("t6_left", 32'(exp_q.size()), 0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
